// File: rtl/iob_fp_acc_ctrl_if.sv
// Bundle of the run-control, element-stream and adder-facing signals of iob_fp_acc_ctrl.
// slave is the controller's view; master is the surrounding logic (source, adder, consumer).
interface iob_fp_acc_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic              busy_o;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              add_start_o;
    logic [DATA_W-1:0] add_op_a_o;
    logic [DATA_W-1:0] add_op_b_o;
    logic              add_done_i;
    logic [DATA_W-1:0] add_res_i;
    logic              add_overflow_i;
    logic              add_underflow_i;
    logic              add_exception_i;
    logic              done_o;
    logic [DATA_W-1:0] res_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              exception_o;

    modport slave (
        input  start_i, len_i, in_valid_i, in_data_i,
        input  add_done_i, add_res_i, add_overflow_i, add_underflow_i, add_exception_i,
        output busy_o, in_ready_o, add_start_o, add_op_a_o, add_op_b_o,
        output done_o, res_o, overflow_o, underflow_o, exception_o
    );

    modport master (
        output start_i, len_i, in_valid_i, in_data_i,
        output add_done_i, add_res_i, add_overflow_i, add_underflow_i, add_exception_i,
        input  busy_o, in_ready_o, add_start_o, add_op_a_o, add_op_b_o,
        input  done_o, res_o, overflow_o, underflow_o, exception_o
    );
endinterface

// File: rtl/iob_fp_acc_ctrl.sv
// Sequencer that folds a run of len_i floats through the shared iob_fp_add, with sticky flags.
// Optional IOB_FP_ACC_ABORT_EN: end the run early on the first adder exception.
module iob_fp_acc_ctrl #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int LEN_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    iob_fp_acc_ctrl_if.slave   bus
);
    localparam logic [DATA_W-1:0] POS_ZERO =
        {1'b0, {EXP_W{1'b0}}, {(DATA_W-EXP_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IN  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ADD = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [LEN_W-1:0]  cnt_inc_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] op_b_r;
    logic [DATA_W-1:0] res_r;
    logic              ovf_r;
    logic              unf_r;
    logic              exc_r;
    logic              busy_r;
    logic              in_ready_r;
    logic              add_start_r;
    logic              done_r;
    logic              start_acc_s;
    logic              in_fire_s;
    logic              add_fire_s;
    logic              finish_s;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle datapath enables
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        in_fire_s   = 1'b0;
        add_fire_s  = 1'b0;
        finish_s    = 1'b0;
        cnt_inc_s   = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    start_acc_s = 1'b1;
                    if (bus.len_i == {LEN_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT_IN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_IN: begin
                if (bus.in_valid_i) begin
                    in_fire_s = 1'b1;
                    state_s   = ISSUE;
                end else begin
                    state_s = WAIT_IN;
                end
            end
            ISSUE: begin
                state_s = WAIT_ADD;
            end
            WAIT_ADD: begin
                if (bus.add_done_i) begin
                    add_fire_s = 1'b1;
`ifdef IOB_FP_ACC_ABORT_EN
                    finish_s = (cnt_inc_s == len_r) || bus.add_exception_i;
`else
                    finish_s = (cnt_inc_s == len_r);
`endif
                    if (finish_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT_IN;
                    end
                end else begin
                    state_s = WAIT_ADD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Run datapath: length, count, running sum, operand B, result and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_r  <= {LEN_W{1'b0}};
            cnt_r  <= {LEN_W{1'b0}};
            acc_r  <= POS_ZERO;
            op_b_r <= {DATA_W{1'b0}};
            res_r  <= POS_ZERO;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            exc_r  <= 1'b0;
        end else if (start_acc_s) begin
            len_r <= bus.len_i;
            cnt_r <= {LEN_W{1'b0}};
            acc_r <= POS_ZERO;
            res_r <= POS_ZERO;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            exc_r <= 1'b0;
        end else if (in_fire_s) begin
            op_b_r <= bus.in_data_i;
        end else if (add_fire_s) begin
            acc_r <= bus.add_res_i;
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | bus.add_overflow_i;
            unf_r <= unf_r | bus.add_underflow_i;
            exc_r <= exc_r | bus.add_exception_i;
            // The result register is loaded on the same edge that enters DONE
            if (finish_s) begin
                res_r <= bus.add_res_i;
            end
        end
    end

    // Control outputs registered from the next state so they are glitch-free
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            add_start_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r      <= (state_s != IDLE);
            in_ready_r  <= (state_s == WAIT_IN);
            add_start_r <= (state_s == ISSUE);
            done_r      <= (state_s == DONE);
        end
    end

    assign bus.busy_o      = busy_r;
    assign bus.in_ready_o  = in_ready_r;
    assign bus.add_start_o = add_start_r;
    assign bus.add_op_a_o  = acc_r;
    assign bus.add_op_b_o  = op_b_r;
    assign bus.done_o      = done_r;
    assign bus.res_o       = res_r;
    assign bus.overflow_o  = ovf_r;
    assign bus.underflow_o = unf_r;
    assign bus.exception_o = exc_r;
endmodule
